// File: rtl/pb_event_ctrl.sv
// pb_event_ctrl: classifies a debounced button level into short/long/double-click/repeat pulses
module pb_event_ctrl #(
  parameter int LONG_CNT = 50_000_000,
  parameter int DCLK_CNT = 15_000_000,
  parameter int RPT_CNT  = 10_000_000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic pb_stbl,
  input  logic en,
  output logic short_press,
  output logic long_press,
  output logic dbl_click,
  output logic repeat_tick,
  output logic busy
);
  localparam int MAX_LD = LONG_CNT > DCLK_CNT ? LONG_CNT : DCLK_CNT;
  localparam int MAX_CNT = MAX_LD > RPT_CNT ? MAX_LD : RPT_CNT;
  localparam int CNT_SZ = $clog2(MAX_CNT);
  localparam logic [CNT_SZ-1:0] LONG_END = CNT_SZ'(LONG_CNT - 1);
  localparam logic [CNT_SZ-1:0] DCLK_END = CNT_SZ'(DCLK_CNT - 1);
  localparam logic [CNT_SZ-1:0] RPT_END  = CNT_SZ'(RPT_CNT - 1);
  typedef enum logic [2:0] {IDLE, PRESSED, HOLD, WAIT2, PRESSED2} state_t;
  state_t state, state_d;
  logic [CNT_SZ-1:0] cnt, cnt_d;
  logic [3:0] ev_d;
  logic pb_q, rise, fall;
  assign rise = pb_stbl & ~pb_q;
  assign fall = ~pb_stbl & pb_q;
  // ev_d packs {short_press, long_press, dbl_click, repeat_tick}
  always_comb begin
    state_d = state;
    cnt_d = cnt + CNT_SZ'(1);
    ev_d = '0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = PRESSED;
      end
      PRESSED:
        if (fall) state_d = WAIT2;
        else if (cnt == LONG_END) begin
          ev_d[2] = 1'b1;
          state_d = HOLD;
        end
      HOLD:
        if (fall) state_d = IDLE;
        else if (cnt == RPT_END) begin
          ev_d[0] = 1'b1;
          cnt_d = '0;
        end
      WAIT2:
        if (rise) begin
          ev_d[1] = 1'b1;
          state_d = PRESSED2;
        end else if (cnt == DCLK_END) begin
          ev_d[3] = 1'b1;
          state_d = IDLE;
        end
      PRESSED2: begin
        cnt_d = '0;
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state) cnt_d = '0;
    if (!en) begin
      state_d = IDLE;
      cnt_d = '0;
      ev_d = '0;
    end
  end
  // pb_q resets high so a button held through reset never registers as a press
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt <= '0;
      pb_q <= 1'b1;
      {short_press, long_press, dbl_click, repeat_tick} <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      pb_q <= pb_stbl;
      {short_press, long_press, dbl_click, repeat_tick} <= ev_d;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_pb_event_ctrl.sv
// tb_pb_event_ctrl: directed gesture vectors plus a randomized run against a time-stamp reference model
module tb_pb_event_ctrl;
  localparam int LONG = 20, DCLK = 8, RPT = 5;
  localparam int S_IDLE = 0, S_PR = 1, S_HOLD = 2, S_W2 = 3, S_PR2 = 4;
  logic clk = 1'b0, arst_n = 1'b0, pb_stbl = 1'b0, en = 1'b1;
  logic short_press, long_press, dbl_click, repeat_tick, busy;
  int n_vec = 0, n_err = 0, cyc = 0, base = 0, start = 0, len = 0;
  int cnt[4], first[4], last[4];
  int ms = S_IDLE, m_enter = 0;
  logic mpq = 1'b1;
  logic [4:0] m_out = '0;
  logic [3:0] prev_ev = '0;
  logic model_on = 1'b0;

  always #5 clk = ~clk;

  pb_event_ctrl #(.LONG_CNT(LONG), .DCLK_CNT(DCLK), .RPT_CNT(RPT)) dut (
    .clk(clk), .arst_n(arst_n), .pb_stbl(pb_stbl), .en(en),
    .short_press(short_press), .long_press(long_press), .dbl_click(dbl_click),
    .repeat_tick(repeat_tick), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic mreset();
    ms = S_IDLE;
    m_enter = 0;
    mpq = 1'b1;
    m_out = '0;
    prev_ev = '0;
  endtask

  // reference model keyed on edges elapsed since entering the current state
  task automatic model_step();
    int c, age, ns;
    logic [3:0] ev;
    logic r, f;
    c = cyc + 1;
    age = c - m_enter;
    ns = ms;
    ev = '0;
    r = pb_stbl & ~mpq;
    f = ~pb_stbl & mpq;
    if (!en) ns = S_IDLE;
    else case (ms)
      S_IDLE: if (r) ns = S_PR;
      S_PR: if (f) ns = S_W2; else if (age == LONG) begin ev = 4'b0100; ns = S_HOLD; end
      S_HOLD: if (f) ns = S_IDLE; else if (age % RPT == 0) ev = 4'b0001;
      S_W2: if (r) begin ev = 4'b0010; ns = S_PR2; end else if (age == DCLK) begin ev = 4'b1000; ns = S_IDLE; end
      default: if (f) ns = S_IDLE;
    endcase
    if (ns != ms) m_enter = c;
    ms = ns;
    mpq = pb_stbl;
    m_out = {ev, ns != S_IDLE};
  endtask

  task automatic mark();
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      first[i] = -1;
      last[i] = -1;
    end
  endtask

  task automatic run(input int n);
    logic [3:0] ev;
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      ev = {short_press, long_press, dbl_click, repeat_tick};
      for (int i = 0; i < 4; i++)
        if (ev[3-i]) begin
          cnt[i]++;
          if (cnt[i] == 1) first[i] = cyc - base;
          last[i] = cyc - base;
        end
      if (model_on) begin
        chk("model", 32'({ev, busy}), 32'(m_out));
        chk("onehot", 32'($onehot0(ev)), 1);
        chk("width", 32'(ev & prev_ev), 0);
      end
      prev_ev = ev;
    end
  endtask

  initial begin
    mark();
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ev", 32'({short_press, long_press, dbl_click, repeat_tick}), 0);
    arst_n = 1'b1;
    run(3);
    chk("idle_busy", 32'(busy), 0);
    // short press
    mark(); pb_stbl = 1'b1; run(1);
    chk("t1_busy_on", 32'(busy), 1);
    run(4); pb_stbl = 1'b0; run(15);
    chk("t1_short_n", cnt[0], 1);
    chk("t1_short_at", first[0], 14);
    chk("t1_other_n", cnt[1] + cnt[2] + cnt[3], 0);
    chk("t1_busy_off", 32'(busy), 0);
    // long press and repeat
    mark(); pb_stbl = 1'b1; run(41); pb_stbl = 1'b0; run(12);
    chk("t2_long_n", cnt[1], 1);
    chk("t2_long_at", first[1], 21);
    chk("t2_tick_n", cnt[3], 4);
    chk("t2_tick_first", first[3], 26);
    chk("t2_tick_last", last[3], 41);
    chk("t2_short_n", cnt[0] + cnt[2], 0);
    chk("t2_busy_off", 32'(busy), 0);
    // double click
    mark(); pb_stbl = 1'b1; run(3); pb_stbl = 1'b0; run(4); pb_stbl = 1'b1; run(3);
    chk("t3_busy_held", 32'(busy), 1);
    pb_stbl = 1'b0; run(1);
    chk("t3_busy_rel", 32'(busy), 0);
    run(11);
    chk("t3_dbl_n", cnt[2], 1);
    chk("t3_dbl_at", first[2], 8);
    chk("t3_other_n", cnt[0] + cnt[1] + cnt[3], 0);
    // second rise on the last window edge
    mark(); pb_stbl = 1'b1; run(2); pb_stbl = 1'b0; run(8); pb_stbl = 1'b1; run(3); pb_stbl = 1'b0; run(5);
    chk("t4a_dbl_n", cnt[2], 1);
    chk("t4a_dbl_at", first[2], 11);
    chk("t4a_short_n", cnt[0], 0);
    chk("t4a_busy_off", 32'(busy), 0);
    // second rise one edge late: short, then a new gesture
    mark(); pb_stbl = 1'b1; run(2); pb_stbl = 1'b0; run(9); pb_stbl = 1'b1; run(3); pb_stbl = 1'b0; run(12);
    chk("t4b_short_n", cnt[0], 2);
    chk("t4b_short_first", first[0], 11);
    chk("t4b_short_last", last[0], 23);
    chk("t4b_dbl_n", cnt[2], 0);
    // enable abort mid-hold, re-enable while pressed
    mark(); pb_stbl = 1'b1; run(10);
    chk("t5_busy_hold", 32'(busy), 1);
    en = 1'b0; run(1);
    chk("t5_busy_abort", 32'(busy), 0);
    run(24); en = 1'b1; run(30); pb_stbl = 1'b0; run(12);
    chk("t5_ev_n", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
    chk("t5_busy_end", 32'(busy), 0);
    // async reset mid-gesture with the button held across release
    pb_stbl = 1'b1; run(25);
    chk("t5r_busy_pre", 32'(busy), 1);
    #2 arst_n = 1'b0;
    #1;
    chk("t5r_busy_rst", 32'(busy), 0);
    chk("t5r_ev_rst", 32'({short_press, long_press, dbl_click, repeat_tick}), 0);
    run(2);
    arst_n = 1'b1;
    mark(); run(30);
    chk("t5r_no_ev", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
    chk("t5r_busy_idle", 32'(busy), 0);
    pb_stbl = 1'b0; run(3); pb_stbl = 1'b1; run(3); pb_stbl = 1'b0; run(12);
    chk("t5r_short_n", cnt[0], 1);
    chk("t5r_short_at", first[0], 45);
    // randomized run cross-checked against the model
    pb_stbl = 1'b0; en = 1'b1; run(3);
    #2 arst_n = 1'b0;
    #1 arst_n = 1'b1;
    mreset();
    model_on = 1'b1;
    start = cyc;
    while (cyc < start + 20000) begin
      pb_stbl = ~pb_stbl;
      len = $urandom_range(1, 45);
      for (int k = 0; k < len; k++) begin
        en = $urandom_range(0, 149) != 0;
        run(1);
      end
    end
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
